rpn_stack_calc: RTL and testbench

- Parametrised successor to the four-function calculator: a signed RPN calculator with a DEPTH-entry operand stack.
- Operands enter in sign-magnitude on NumberSM and are stored in two's complement.
- Add/Subtract complete in one cycle. Multiply/Divide run on an iterative shift-add / restoring datapath.
- Sits between the board switches/buttons and the display driver.
- Adds behaviour the previous generation lacked: stack buffering, button edge detection, Busy handshake, and distinct Underflow/DivByZero flags.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/rpn_stack_calc_if.sv | 31 +++
 rtl/seq_muldiv.sv | 98 +++++++++
 rtl/rpn_stack_calc.sv | 137 +++++++++++++
 tb/tb_rpn_stack_calc.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, flag indices and command priority encoder for rpn_stack_calc
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ENTER,
    OP_DROP,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_DBZ  = 1;
  localparam int FLAG_UNF  = 2;
  localparam int NUM_FLAGS = 3;

  localparam int BTN_ENTER = 0;
  localparam int BTN_DROP  = 1;
  localparam int BTN_ADD   = 2;
  localparam int BTN_SUB   = 3;
  localparam int BTN_MUL   = 4;
  localparam int BTN_DIV   = 5;
  localparam int NUM_BTNS  = 6;

  // Lowest button index wins when several edges land in the same cycle.
  function automatic op_e prio_encode(input logic [NUM_BTNS-1:0] rise);
    if (rise[BTN_ENTER])     return OP_ENTER;
    else if (rise[BTN_DROP]) return OP_DROP;
    else if (rise[BTN_ADD])  return OP_ADD;
    else if (rise[BTN_SUB])  return OP_SUB;
    else if (rise[BTN_MUL])  return OP_MUL;
    else if (rise[BTN_DIV])  return OP_DIV;
    else                     return OP_NOP;
  endfunction

endpackage

// File: rtl/rpn_stack_calc_if.sv
// rtl/rpn_stack_calc_if.sv - button/operand inputs and display-side outputs of rpn_stack_calc
interface rpn_stack_calc_if #(
  parameter int W     = 11,
  parameter int DEPTH = 4
);
  logic                         Enter;
  logic                         Drop;
  logic                         Add;
  logic                         Subtract;
  logic                         Multiply;
  logic                         Divide;
  logic [W-1:0]                 NumberSM;
  logic [W-1:0]                 Result;
  logic                         Busy;
  logic                         Overflow;
  logic                         DivByZero;
  logic                         Underflow;
  logic [$clog2(DEPTH+1)-1:0]   Depth;
  logic                         StackFull;
  logic [1:0]                   State;

  modport master (
    output Enter, Drop, Add, Subtract, Multiply, Divide, NumberSM,
    input  Result, Busy, Overflow, DivByZero, Underflow, Depth, StackFull, State
  );

  modport slave (
    input  Enter, Drop, Add, Subtract, Multiply, Divide, NumberSM,
    output Result, Busy, Overflow, DivByZero, Underflow, Depth, StackFull, State
  );
endinterface

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - W-cycle shift-add multiplier / restoring divider on magnitudes with sign fix-up
module seq_muldiv #(
  parameter int W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                is_div_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic                last_o,
  output logic signed [W-1:0] result_o,
  output logic                ovf_o
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0]    LAST    = CW'(W - 1);
  localparam logic [2*W-1:0]   POS_MAX = (2*W)'((64'd1 << (W - 1)) - 64'd1);
  localparam logic [2*W-1:0]   NEG_MAX = POS_MAX + 1'b1;

  logic          run_q, run_d;
  logic          div_q, div_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  b_q, b_d;
  logic [W:0]    hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W:0]    sum, trial;
  logic [2*W-1:0] mag;
  logic [W-1:0]  mag_lo;

  function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  // hi/lo hold {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    run_d = run_q;
    div_d = div_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    sum   = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
    trial = {hi_q[W-1:0], lo_q[W-1]};
    if (start_i) begin
      run_d = 1'b1;
      div_d = is_div_i;
      neg_d = a_i[W-1] ^ b_i[W-1];
      cnt_d = '0;
      b_d   = mag_of(b_i);
      hi_d  = '0;
      lo_d  = mag_of(a_i);
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      run_d = (cnt_q != LAST);
      if (div_q) begin
        if (trial >= {1'b0, b_q}) begin
          hi_d = trial - {1'b0, b_q};
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = trial;
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = {1'b0, sum[W:1]};
        lo_d = {sum[0], lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign last_o   = run_q && (cnt_q == LAST);
  assign mag      = div_q ? {{W{1'b0}}, lo_q} : {hi_q[W-1:0], lo_q};
  assign mag_lo   = mag[W-1:0];
  assign ovf_o    = mag > (neg_q ? NEG_MAX : POS_MAX);
  assign result_o = neg_q ? (~mag_lo + 1'b1) : mag_lo;

endmodule

// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc - signed RPN calculator: edge-detected buttons, DEPTH-entry TC stack, iterative mul/div
module rpn_stack_calc
  import calc_pkg::*;
#(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input logic            Clock,
  input logic            Clear,
  rpn_stack_calc_if.slave io
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_e               state_q, state_d;
  logic [W-1:0]         stack_q [DEPTH];
  logic [W-1:0]         stack_d [DEPTH];
  logic [DW-1:0]        depth_q, depth_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_BTNS-1:0]  btn_q, btn_d;
  op_e                  op;
  logic [W-1:0]         num_tc, nos, tos, md_result;
  logic [W:0]           alu;
  logic                 alu_ovf, md_start, md_last, md_ovf;

  // History follows the buttons even while busy so a press during an op never fires late.
  assign btn_d  = {io.Divide, io.Multiply, io.Subtract, io.Add, io.Drop, io.Enter};
  assign op     = (state_q == ST_IDLE) ? prio_encode(btn_d & ~btn_q) : OP_NOP;
  assign num_tc = io.NumberSM[W-1] ? (~{1'b0, io.NumberSM[W-2:0]} + 1'b1)
                                   : {1'b0, io.NumberSM[W-2:0]};
  assign nos     = stack_q[1];
  assign tos     = stack_q[0];
  assign alu     = (op == OP_SUB) ? ({nos[W-1], nos} - {tos[W-1], tos})
                                  : ({nos[W-1], nos} + {tos[W-1], tos});
  assign alu_ovf = alu[W] ^ alu[W-1];

  seq_muldiv #(.W(W)) u_muldiv (
    .clk      (Clock),
    .rst      (Clear),
    .start_i  (md_start),
    .is_div_i (op == OP_DIV),
    .a_i      (nos),
    .b_i      (tos),
    .last_o   (md_last),
    .result_o (md_result),
    .ovf_o    (md_ovf)
  );

  always_comb begin
    state_d  = state_q;
    stack_d  = stack_q;
    depth_d  = depth_q;
    flags_d  = flags_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (op)
          OP_ENTER: begin
            stack_d[0] = num_tc;
            for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
            if (depth_q != FULL) depth_d = depth_q + 1'b1;
          end
          OP_DROP: begin
            if (depth_q != '0) begin
              for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
              stack_d[DEPTH-1] = '0;
              depth_d = depth_q - 1'b1;
            end
          end
          OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
            flags_d = '0;
            if (depth_q < DW'(2)) begin
              flags_d[FLAG_UNF] = 1'b1;
            end else if (op == OP_DIV && tos == '0) begin
              flags_d[FLAG_DBZ] = 1'b1;
            end else if (op == OP_MUL || op == OP_DIV) begin
              flags_d  = flags_q;
              md_start = 1'b1;
              state_d  = (op == OP_MUL) ? ST_MUL : ST_DIV;
            end else if (alu_ovf) begin
              flags_d[FLAG_OVF] = 1'b1;
            end else begin
              stack_d[0] = alu[W-1:0];
              for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
              stack_d[DEPTH-1] = '0;
              depth_d = depth_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_MUL, ST_DIV: begin
        if (md_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        flags_d = '0;
        if (md_ovf) begin
          flags_d[FLAG_OVF] = 1'b1;
        end else begin
          stack_d[0] = md_result;
          for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          stack_d[DEPTH-1] = '0;
          depth_d = depth_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      depth_q <= '0;
      flags_q <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      flags_q <= flags_d;
      btn_q   <= btn_d;
    end
  end

  // Entries at or below Depth are kept zero, so TOS reads 0 on an empty stack.
  assign io.Result    = stack_q[0];
  assign io.Busy      = (state_q != ST_IDLE);
  assign io.Overflow  = flags_q[FLAG_OVF];
  assign io.DivByZero = flags_q[FLAG_DBZ];
  assign io.Underflow = flags_q[FLAG_UNF];
  assign io.Depth     = depth_q;
  assign io.StackFull = (depth_q == FULL);
  assign io.State     = state_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// tb/tb_rpn_stack_calc.sv - scoreboard bench for rpn_stack_calc with directed hand-computed vectors
module tb_rpn_stack_calc;
  import calc_pkg::*;

  localparam int W     = 11;
  localparam int DEPTH = 4;

  typedef struct {
    string name;
    int    result;
    int    depth;
    bit    ovf;
    bit    dbz;
    bit    unf;
    int    busy;
  } exp_t;

  logic Clock = 1'b0;
  logic Clear = 1'b1;
  exp_t exp_q[$];
  exp_t cur;
  exp_t item;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_acc = 0;
  int   act_res;
  bit   ok;

  rpn_stack_calc_if #(.W(W), .DEPTH(DEPTH)) io ();

  rpn_stack_calc #(.W(W), .DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .io    (io.slave)
  );

  always #5 Clock = ~Clock;

  // Monitor: counts Busy cycles and checks the oldest expectation once the DUT is idle.
  always @(negedge Clock) begin
    if (io.Busy) busy_acc++;
    if (exp_q.size() != 0 && !io.Busy) begin
      cur = exp_q.pop_front();
      vectors++;
      act_res = int'($signed(io.Result));
      ok = (act_res == cur.result) && (int'(io.Depth) == cur.depth) &&
           (io.StackFull == (cur.depth == DEPTH)) && (io.Overflow == cur.ovf) &&
           (io.DivByZero == cur.dbz) && (io.Underflow == cur.unf) && (io.State == 2'd0) &&
           (cur.busy < 0 || busy_acc == cur.busy);
      if (!ok) begin
        miscompares++;
        $display("FAIL %s: got Result=%0d Depth=%0d Full=%0b OZU=%0b%0b%0b State=%0d busy=%0d; want Result=%0d Depth=%0d Full=%0b OZU=%0b%0b%0b State=0 busy=%0d",
                 cur.name, act_res, io.Depth, io.StackFull, io.Overflow, io.DivByZero, io.Underflow,
                 io.State, busy_acc, cur.result, cur.depth, cur.depth == DEPTH, cur.ovf, cur.dbz,
                 cur.unf, cur.busy);
      end
      busy_acc = 0;
    end
  end

  task automatic set_btns(input logic [NUM_BTNS-1:0] b);
    io.Enter    = b[BTN_ENTER];
    io.Drop     = b[BTN_DROP];
    io.Add      = b[BTN_ADD];
    io.Subtract = b[BTN_SUB];
    io.Multiply = b[BTN_MUL];
    io.Divide   = b[BTN_DIV];
  endtask

  task automatic pulse(input logic [NUM_BTNS-1:0] b, input int hold);
    @(negedge Clock);
    set_btns(b);
    repeat (hold) @(negedge Clock);
    set_btns('0);
    @(negedge Clock);
  endtask

  task automatic enter(input logic [W-1:0] sm);
    io.NumberSM = sm;
    pulse(6'b000001, 1);
  endtask

  task automatic op(input int btn);
    logic [NUM_BTNS-1:0] b;
    b = '0;
    b[btn] = 1'b1;
    pulse(b, 1);
  endtask

  task automatic do_clear();
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic chk(input string name, input int res, input int dep,
                     input bit ovf, input bit dbz, input bit unf, input int busy);
    item.name = name; item.result = res; item.depth = dep;
    item.ovf = ovf; item.dbz = dbz; item.unf = unf; item.busy = busy;
    exp_q.push_back(item);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge Clock);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: DUT stayed Busy=%0b past 300 cycles, required idle", name, io.Busy);
      exp_q.delete();
    end
  endtask

  initial begin
    io.NumberSM = '0;
    set_btns('0);
    repeat (2) @(negedge Clock);
    Clear = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 0);

    enter(11'h001); enter(11'h003); op(BTN_ADD);
    chk("add_1_3", 4, 1, 0, 0, 0, 0);
    enter(11'h005); op(BTN_SUB);
    chk("sub_4_5", -1, 1, 0, 0, 0, 0);

    enter(11'h3FF); enter(11'h7FF); op(BTN_ADD);
    chk("add_1023_m1023", 0, 2, 0, 0, 0, 0);
    do_clear();
    enter(11'h3FF); enter(11'h00A); op(BTN_ADD);
    chk("add_overflow", 10, 2, 1, 0, 0, 0);

    do_clear();
    enter(11'h40C); enter(11'h005); op(BTN_MUL);
    chk("mul_m12_5", -60, 1, 0, 0, 0, 12);
    enter(11'h007); op(BTN_DIV);
    chk("div_m60_7", -8, 1, 0, 0, 0, 12);
    enter(11'h000); op(BTN_DIV);
    chk("div_by_zero", 0, 2, 0, 1, 0, 0);

    do_clear();
    enter(11'h064); enter(11'h064); op(BTN_MUL);
    chk("mul_overflow", 100, 2, 1, 0, 0, 12);
    do_clear();
    enter(11'h7FF); enter(11'h401); op(BTN_ADD);
    chk("add_to_min", -1024, 1, 0, 0, 0, 0);
    enter(11'h401); op(BTN_DIV);
    chk("div_min_by_m1", -1, 2, 1, 0, 0, 12);

    do_clear();
    for (int v = 1; v <= 5; v++) enter(11'(v));
    chk("fill_5", 5, 4, 0, 0, 0, 0);
    op(BTN_DROP); chk("drop1", 4, 3, 0, 0, 0, 0);
    op(BTN_DROP); chk("drop2", 3, 2, 0, 0, 0, 0);
    op(BTN_DROP); chk("drop3", 2, 1, 0, 0, 0, 0);
    op(BTN_DROP); chk("drop4_empty", 0, 0, 0, 0, 0, 0);
    op(BTN_ADD);  chk("add_underflow", 0, 0, 0, 0, 1, 0);
    op(BTN_DROP); chk("drop_empty_noop", 0, 0, 0, 0, 1, 0);

    do_clear();
    enter(11'h002); enter(11'h003); enter(11'h004);
    pulse(6'b000100, 3);
    chk("add_held", 7, 2, 0, 0, 0, 0);
    pulse(6'b001100, 1);
    chk("add_sub_same_edge", 9, 1, 0, 0, 0, 0);
    enter(11'h003);
    @(negedge Clock); set_btns(6'b010000);
    @(negedge Clock); set_btns('0);
    repeat (3) @(negedge Clock);
    set_btns(6'b100000);
    chk("mul_div_while_busy", 27, 1, 0, 0, 0, 12);
    @(negedge Clock); set_btns('0);
    repeat (2) @(negedge Clock);
    chk("div_after_busy_ignored", 27, 1, 0, 0, 0, 0);

    enter(11'h006); enter(11'h007); op(BTN_MUL);
    repeat (3) @(posedge Clock);
    #2 Clear = 1'b1;
    chk("clear_mid_mul", 0, 0, 0, 0, 0, -1);
    Clear = 1'b0;
    repeat (15) @(negedge Clock);
    chk("no_write_after_clear", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
